// File: rtl/ex_csr_port_arb.sv
// rtl/ex_csr_port_arb.sv - two-requester arbiter for the single CSR-file access port
// One transaction in flight: IDLE (grant) -> ACCESS (1-cycle strobe) -> RESP (hold until taken).
module ex_csr_port_arb #(
  parameter int XLEN     = 32,
  parameter int IDX_W    = 12,
  parameter int DBG_PRIO = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [IDX_W-1:0] req0_idx,
  input  logic             req0_wr_en,
  input  logic             req0_rd_en,
  input  logic [XLEN-1:0]  req0_wdat,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [IDX_W-1:0] req1_idx,
  input  logic             req1_wr_en,
  input  logic             req1_rd_en,
  input  logic [XLEN-1:0]  req1_wdat,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [XLEN-1:0]  rsp_rdat,
  output logic             rsp_err,
  output logic             csr_ena,
  output logic             csr_wr_en,
  output logic             csr_rd_en,
  output logic [IDX_W-1:0] csr_idx,
  output logic [XLEN-1:0]  wbck_csr_dat,
  input  logic [XLEN-1:0]  read_csr_dat,
  input  logic             csr_access_ilgl
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             owner_q, owner_d;
  logic             rr_last_q, rr_last_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             wr_q, wr_d;
  logic             rd_q, rd_d;
  logic [XLEN-1:0]  wdat_q, wdat_d;
  logic [XLEN-1:0]  rdat_q, rdat_d;
  logic             err_q, err_d;
  logic             ena_q, ena_d;

  logic is_idle;
  logic grant1;
  logic accept;

  // rr_last_q names the requester granted last; the other one wins a tie in round-robin mode.
  always_comb begin
    grant1 = req1_valid;
    if (req0_valid && req1_valid) begin
      grant1 = (DBG_PRIO != 0) ? 1'b1 : ~rr_last_q;
    end
  end

  assign is_idle    = (state_q == S_IDLE) && !rst;
  assign req1_ready = is_idle && req1_valid && grant1;
  assign req0_ready = is_idle && req0_valid && !grant1;
  assign accept     = req0_ready || req1_ready;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_last_d = rr_last_q;
    idx_d     = idx_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    wdat_d    = wdat_q;
    rdat_d    = rdat_q;
    err_d     = err_q;
    ena_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d   = S_ACCESS;
          owner_d   = grant1;
          rr_last_d = grant1;
          idx_d     = grant1 ? req1_idx   : req0_idx;
          wr_d      = grant1 ? req1_wr_en : req0_wr_en;
          rd_d      = grant1 ? req1_rd_en : req0_rd_en;
          wdat_d    = grant1 ? req1_wdat  : req0_wdat;
          ena_d     = 1'b1;
        end
      end
      S_ACCESS: begin
        state_d = S_RESP;
        err_d   = csr_access_ilgl;
        rdat_d  = (csr_access_ilgl || !rd_q) ? '0 : read_csr_dat;
      end
      S_RESP: begin
        if (owner_q ? rsp1_ready : rsp0_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      owner_q   <= 1'b0;
      rr_last_q <= 1'b1;
      idx_q     <= '0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      wdat_q    <= '0;
      rdat_q    <= '0;
      err_q     <= 1'b0;
      ena_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_last_q <= rr_last_d;
      idx_q     <= idx_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      wdat_q    <= wdat_d;
      rdat_q    <= rdat_d;
      err_q     <= err_d;
      ena_q     <= ena_d;
    end
  end

  assign csr_ena      = ena_q;
  assign csr_wr_en    = ena_q && wr_q;
  assign csr_rd_en    = ena_q && rd_q;
  assign csr_idx      = idx_q;
  assign wbck_csr_dat = wdat_q;
  assign rsp_rdat     = rdat_q;
  assign rsp_err      = err_q;
  assign rsp0_valid   = (state_q == S_RESP) && !owner_q;
  assign rsp1_valid   = (state_q == S_RESP) && owner_q;

endmodule

// File: tb/tb_ex_csr_port_arb.sv
// tb/tb_ex_csr_port_arb.sv - self-checking bench for ex_csr_port_arb
// Two instances (fixed debug priority, round-robin) share every input and are checked against one model.
module tb_ex_csr_port_arb;

  logic clk, rst;
  logic v0, w0, r0, rr0, v1, w1, r1, rr1, ilgl;
  logic [11:0] i0, i1;
  logic [31:0] d0, d1, rdat;

  logic req0_ready_p, req1_ready_p, rsp0_valid_p, rsp1_valid_p, rsp_err_p;
  logic csr_ena_p, csr_wr_en_p, csr_rd_en_p;
  logic [11:0] csr_idx_p;
  logic [31:0] wbck_p, rsp_rdat_p;
  logic req0_ready_r, req1_ready_r, rsp0_valid_r, rsp1_valid_r, rsp_err_r;
  logic csr_ena_r, csr_wr_en_r, csr_rd_en_r;
  logic [11:0] csr_idx_r;
  logic [31:0] wbck_r, rsp_rdat_r;

  int n_checks = 0;
  int n_fail   = 0;
  int last_rr  = 1;
  int ena_cnt[2];
  int acc_cnt[2];
  logic prev_ena[2];

  ex_csr_port_arb #(.XLEN(32), .IDX_W(12), .DBG_PRIO(1)) u_prio (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_ready(req0_ready_p), .req0_idx(i0), .req0_wr_en(w0), .req0_rd_en(r0),
    .req0_wdat(d0), .rsp0_valid(rsp0_valid_p), .rsp0_ready(rr0),
    .req1_valid(v1), .req1_ready(req1_ready_p), .req1_idx(i1), .req1_wr_en(w1), .req1_rd_en(r1),
    .req1_wdat(d1), .rsp1_valid(rsp1_valid_p), .rsp1_ready(rr1),
    .rsp_rdat(rsp_rdat_p), .rsp_err(rsp_err_p),
    .csr_ena(csr_ena_p), .csr_wr_en(csr_wr_en_p), .csr_rd_en(csr_rd_en_p), .csr_idx(csr_idx_p),
    .wbck_csr_dat(wbck_p), .read_csr_dat(rdat), .csr_access_ilgl(ilgl)
  );

  ex_csr_port_arb #(.XLEN(32), .IDX_W(12), .DBG_PRIO(0)) u_rr (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_ready(req0_ready_r), .req0_idx(i0), .req0_wr_en(w0), .req0_rd_en(r0),
    .req0_wdat(d0), .rsp0_valid(rsp0_valid_r), .rsp0_ready(rr0),
    .req1_valid(v1), .req1_ready(req1_ready_r), .req1_idx(i1), .req1_wr_en(w1), .req1_rd_en(r1),
    .req1_wdat(d1), .rsp1_valid(rsp1_valid_r), .rsp1_ready(rr1),
    .rsp_rdat(rsp_rdat_r), .rsp_err(rsp_err_r),
    .csr_ena(csr_ena_r), .csr_wr_en(csr_wr_en_r), .csr_rd_en(csr_rd_en_r), .csr_idx(csr_idx_r),
    .wbck_csr_dat(wbck_r), .read_csr_dat(rdat), .csr_access_ilgl(ilgl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] rdy_of(input int i);
    if (i == 0) return {req1_ready_p, req0_ready_p};
    return {req1_ready_r, req0_ready_r};
  endfunction

  function automatic logic [46:0] csr_of(input int i);
    if (i == 0) return {csr_ena_p, csr_wr_en_p, csr_rd_en_p, csr_idx_p, wbck_p};
    return {csr_ena_r, csr_wr_en_r, csr_rd_en_r, csr_idx_r, wbck_r};
  endfunction

  function automatic logic [34:0] rsp_of(input int i);
    if (i == 0) return {rsp1_valid_p, rsp0_valid_p, rsp_err_p, rsp_rdat_p};
    return {rsp1_valid_r, rsp0_valid_r, rsp_err_r, rsp_rdat_r};
  endfunction

  // Winner from the arbitration rules: lone valid wins; tie goes to debug (inst 0) or the one not granted last.
  function automatic int model_win(input int inst, input logic a0, input logic a1, input int last);
    if (a0 && !a1) return 0;
    if (a1 && !a0) return 1;
    if (inst == 0) return 1;
    return (last == 1) ? 0 : 1;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        n_checks++;
        if (rdy_of(i) == 2'b11) begin
          n_fail++; $display("FAIL both_ready inst%0d got %b exp not 11", i, rdy_of(i));
        end
        n_checks++;
        if (rsp_of(i)[34:33] == 2'b11) begin
          n_fail++; $display("FAIL both_rsp_valid inst%0d got %b exp not 11", i, rsp_of(i)[34:33]);
        end
        n_checks++;
        if (csr_of(i)[46] && prev_ena[i]) begin
          n_fail++; $display("FAIL ena_width inst%0d got 2 consecutive cycles exp 1", i);
        end
        prev_ena[i] = csr_of(i)[46];
        ena_cnt[i] += int'(csr_of(i)[46]);
        acc_cnt[i] += int'(|(rdy_of(i) & {v1, v0}));
      end
    end else begin
      prev_ena[0] = 1'b0;
      prev_ena[1] = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic clear_in();
    v0 = 0; w0 = 0; r0 = 0; i0 = '0; d0 = '0; rr0 = 0;
    v1 = 0; w1 = 0; r1 = 0; i1 = '0; d1 = '0; rr1 = 0;
    rdat = '0; ilgl = 0;
  endtask

  task automatic do_reset();
    rst = 1; clear_in();
    @(posedge clk); @(posedge clk); #1;
    rst = 0; last_rr = 1;
  endtask

  task automatic test_reset();
    rst = 1; clear_in();
    v0 = 1; v1 = 1;
    @(posedge clk); @(posedge clk); #2;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (rdy_of(i) !== 2'b00) begin
        n_fail++; $display("FAIL reset_ready inst%0d got %b exp 00", i, rdy_of(i));
      end
      n_checks++;
      if (rsp_of(i) !== '0) begin
        n_fail++; $display("FAIL reset_rsp inst%0d got %h exp 0", i, rsp_of(i));
      end
      n_checks++;
      if (csr_of(i) !== '0) begin
        n_fail++; $display("FAIL reset_csr inst%0d got %h exp 0", i, csr_of(i));
      end
    end
    @(posedge clk); #1;
    v0 = 0; v1 = 0; rst = 0; last_rr = 1;
  endtask

  task automatic test_write();
    v0 = 1; w0 = 1; r0 = 0; i0 = 12'h300; d0 = 32'h88; rr0 = 1;
    #1;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (rdy_of(i) !== 2'b01) begin
        n_fail++; $display("FAIL write_ready inst%0d got %b exp 01", i, rdy_of(i));
      end
    end
    step(); v0 = 0; rdat = 32'hCAFE0000; ilgl = 0; #1;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (csr_of(i) !== {1'b1, 1'b1, 1'b0, 12'h300, 32'h88}) begin
        n_fail++; $display("FAIL write_access inst%0d got %h exp %h", i, csr_of(i), {1'b1, 1'b1, 1'b0, 12'h300, 32'h88});
      end
    end
    step(); #1;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (rsp_of(i) !== {2'b01, 1'b0, 32'h0} || csr_of(i)[46] !== 1'b0) begin
        n_fail++; $display("FAIL write_rsp inst%0d got %h ena %b exp %h ena 0", i, rsp_of(i), csr_of(i)[46], {2'b01, 1'b0, 32'h0});
      end
    end
    step(); #1;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (rsp_of(i)[34:33] !== 2'b00) begin
        n_fail++; $display("FAIL write_done inst%0d got %b exp 00", i, rsp_of(i)[34:33]);
      end
    end
    rr0 = 0; w0 = 0; last_rr = 0;
  endtask

  task automatic test_hold();
    v1 = 1; r1 = 1; w1 = 0; i1 = 12'h7B0; d1 = '0;
    #1;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (rdy_of(i) !== 2'b10) begin
        n_fail++; $display("FAIL hold_ready inst%0d got %b exp 10", i, rdy_of(i));
      end
    end
    step(); v1 = 0; rdat = 32'hDEADBEEF; ilgl = 0; rr1 = 0; #1;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (csr_of(i) !== {1'b1, 1'b0, 1'b1, 12'h7B0, 32'h0}) begin
        n_fail++; $display("FAIL hold_access inst%0d got %h exp %h", i, csr_of(i), {1'b1, 1'b0, 1'b1, 12'h7B0, 32'h0});
      end
    end
    step();
    for (int k = 0; k < 4; k++) begin
      v0 = 1; rdat = $urandom; #1;
      for (int i = 0; i < 2; i++) begin
        n_checks++;
        if (rsp_of(i) !== {2'b10, 1'b0, 32'hDEADBEEF} || rdy_of(i) !== 2'b00 || csr_of(i)[46] !== 1'b0) begin
          n_fail++; $display("FAIL hold_stable inst%0d cyc%0d got rsp %h rdy %b ena %b exp rsp %h rdy 00 ena 0",
                             i, k, rsp_of(i), rdy_of(i), csr_of(i)[46], {2'b10, 1'b0, 32'hDEADBEEF});
        end
      end
      step();
    end
    v0 = 0; rr1 = 1;
    step(); #1;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (rsp_of(i)[34:33] !== 2'b00) begin
        n_fail++; $display("FAIL hold_release inst%0d got %b exp 00", i, rsp_of(i)[34:33]);
      end
    end
    rr1 = 0; r1 = 0; last_rr = 1;
  endtask

  task automatic test_arb();
    int gport[2][8];
    int gcyc[2][8];
    int gcnt[2];
    int last;
    int exp_port;
    do_reset();
    gcnt[0] = 0; gcnt[1] = 0;
    v0 = 1; v1 = 1; r0 = 1; r1 = 1; i0 = 12'h001; i1 = 12'h002; rr0 = 1; rr1 = 1; rdat = 32'h1;
    for (int c = 0; c < 12; c++) begin
      #1;
      for (int i = 0; i < 2; i++) begin
        if (rdy_of(i) != 2'b00 && gcnt[i] < 8) begin
          gport[i][gcnt[i]] = rdy_of(i)[1] ? 1 : 0;
          gcyc[i][gcnt[i]]  = c;
          gcnt[i]++;
        end
      end
      step();
    end
    v0 = 0; v1 = 0;
    step();
    rr0 = 0; rr1 = 0;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (gcnt[i] != 4) begin
        n_fail++; $display("FAIL arb_count inst%0d got %0d exp 4", i, gcnt[i]);
      end
      last = 1;
      for (int g = 0; g < 4 && g < gcnt[i]; g++) begin
        exp_port = model_win(i, 1'b1, 1'b1, last);
        last = exp_port;
        n_checks++;
        if (gport[i][g] != exp_port || gcyc[i][g] != 3 * g) begin
          n_fail++; $display("FAIL arb_grant inst%0d #%0d got port %0d cyc %0d exp port %0d cyc %0d",
                             i, g, gport[i][g], gcyc[i][g], exp_port, 3 * g);
        end
      end
      if (i == 1) last_rr = last;
    end
    r0 = 0; r1 = 0;
  endtask

  task automatic test_ilgl();
    v0 = 1; r0 = 1; w0 = 0; i0 = 12'h001;
    #1;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (rdy_of(i) !== 2'b01) begin
        n_fail++; $display("FAIL ilgl_ready inst%0d got %b exp 01", i, rdy_of(i));
      end
    end
    step(); v0 = 0; rdat = 32'h12345678; ilgl = 1; rr0 = 1;
    step(); ilgl = 0; #1;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (rsp_of(i) !== {2'b01, 1'b1, 32'h0}) begin
        n_fail++; $display("FAIL ilgl_rsp inst%0d got %h exp %h", i, rsp_of(i), {2'b01, 1'b1, 32'h0});
      end
    end
    step(); rr0 = 0; r0 = 0; last_rr = 0;
  endtask

  task automatic test_nop();
    v1 = 1; w1 = 0; r1 = 0; i1 = 12'h5A5; d1 = 32'h77;
    #1;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (rdy_of(i) !== 2'b10) begin
        n_fail++; $display("FAIL nop_ready inst%0d got %b exp 10", i, rdy_of(i));
      end
    end
    step(); v1 = 0; rdat = 32'hFFFFFFFF; ilgl = 0; rr1 = 1; #1;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (csr_of(i) !== {1'b1, 1'b0, 1'b0, 12'h5A5, 32'h77}) begin
        n_fail++; $display("FAIL nop_access inst%0d got %h exp %h", i, csr_of(i), {1'b1, 1'b0, 1'b0, 12'h5A5, 32'h77});
      end
    end
    step(); #1;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (rsp_of(i) !== {2'b10, 1'b0, 32'h0}) begin
        n_fail++; $display("FAIL nop_rsp inst%0d got %h exp %h", i, rsp_of(i), {2'b10, 1'b0, 32'h0});
      end
    end
    step(); rr1 = 0; last_rr = 1;
  endtask

  task automatic test_rst_mid();
    v1 = 1; r1 = 1; i1 = 12'h7B0;
    step(); v1 = 0; rdat = 32'h55AA55AA; rr1 = 0;
    step(); #1;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (rsp_of(i) !== {2'b10, 1'b0, 32'h55AA55AA}) begin
        n_fail++; $display("FAIL rstmid_pre inst%0d got %h exp %h", i, rsp_of(i), {2'b10, 1'b0, 32'h55AA55AA});
      end
    end
    #1 rst = 1;
    #1;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (rsp_of(i) !== '0 || csr_of(i)[46] !== 1'b0) begin
        n_fail++; $display("FAIL rstmid_async inst%0d got rsp %h ena %b exp 0", i, rsp_of(i), csr_of(i)[46]);
      end
    end
    @(posedge clk); #1 rst = 0; last_rr = 1; r1 = 0; i1 = '0;
    #1;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (rsp_of(i) !== '0 || csr_of(i) !== '0) begin
        n_fail++; $display("FAIL rstmid_idle inst%0d got rsp %h csr %h exp 0", i, rsp_of(i), csr_of(i));
      end
    end
    v0 = 1; w0 = 1; r0 = 1; i0 = 12'h341; d0 = 32'h1234; rr0 = 1;
    #1;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (rdy_of(i) !== 2'b01) begin
        n_fail++; $display("FAIL rstmid_ready inst%0d got %b exp 01", i, rdy_of(i));
      end
    end
    step(); v0 = 0; rdat = 32'hA5A5A5A5; #1;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (csr_of(i) !== {1'b1, 1'b1, 1'b1, 12'h341, 32'h1234}) begin
        n_fail++; $display("FAIL rstmid_access inst%0d got %h exp %h", i, csr_of(i), {1'b1, 1'b1, 1'b1, 12'h341, 32'h1234});
      end
    end
    step(); #1;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (rsp_of(i) !== {2'b01, 1'b0, 32'hA5A5A5A5}) begin
        n_fail++; $display("FAIL rstmid_rsp inst%0d got %h exp %h", i, rsp_of(i), {2'b01, 1'b0, 32'hA5A5A5A5});
      end
    end
    step(); rr0 = 0; w0 = 0; r0 = 0; last_rr = 0;
  endtask

  task automatic test_random();
    int win[2];
    logic [46:0] exp_csr;
    logic [34:0] exp_rsp;
    logic [31:0] exp_dat[2];
    logic t_ilgl;
    int dly;
    logic [1:0] pat;
    do_reset();
    for (int t = 0; t < 60; t++) begin
      pat = 2'($urandom_range(1, 3));
      v0 = pat[0]; v1 = pat[1];
      i0 = 12'($urandom); i1 = 12'($urandom); d0 = $urandom; d1 = $urandom;
      w0 = 1'($urandom); r0 = 1'($urandom); w1 = 1'($urandom); r1 = 1'($urandom);
      for (int i = 0; i < 2; i++) win[i] = model_win(i, v0, v1, last_rr);
      #1;
      for (int i = 0; i < 2; i++) begin
        n_checks++;
        if (rdy_of(i) !== ((win[i] == 1) ? 2'b10 : 2'b01)) begin
          n_fail++; $display("FAIL rand_ready t%0d inst%0d got %b exp port %0d", t, i, rdy_of(i), win[i]);
        end
      end
      step();
      v0 = 0; v1 = 0; rdat = $urandom; t_ilgl = ($urandom_range(0, 3) == 0); ilgl = t_ilgl;
      #1;
      for (int i = 0; i < 2; i++) begin
        exp_csr = (win[i] == 1) ? {1'b1, w1, r1, i1, d1} : {1'b1, w0, r0, i0, d0};
        exp_dat[i] = (t_ilgl || !((win[i] == 1) ? r1 : r0)) ? 32'h0 : rdat;
        n_checks++;
        if (csr_of(i) !== exp_csr) begin
          n_fail++; $display("FAIL rand_access t%0d inst%0d got %h exp %h", t, i, csr_of(i), exp_csr);
        end
      end
      step();
      dly = $urandom_range(0, 3);
      for (int k = 0; k <= dly; k++) begin
        rr0 = (k == dly); rr1 = (k == dly);
        v0 = (k < dly) ? 1'($urandom) : 1'b0;
        v1 = (k < dly) ? 1'($urandom) : 1'b0;
        rdat = $urandom; ilgl = 1'($urandom);
        #1;
        for (int i = 0; i < 2; i++) begin
          exp_rsp = {(win[i] == 1), (win[i] == 0), t_ilgl, exp_dat[i]};
          n_checks++;
          if (rsp_of(i) !== exp_rsp || rdy_of(i) !== 2'b00) begin
            n_fail++; $display("FAIL rand_rsp t%0d inst%0d got rsp %h rdy %b exp rsp %h rdy 00", t, i, rsp_of(i), rdy_of(i), exp_rsp);
          end
        end
        step();
      end
      rr0 = 0; rr1 = 0; ilgl = 0;
      #1;
      for (int i = 0; i < 2; i++) begin
        n_checks++;
        if (rsp_of(i)[34:33] !== 2'b00 || csr_of(i)[46] !== 1'b0) begin
          n_fail++; $display("FAIL rand_idle t%0d inst%0d got rsp %b ena %b exp 00 0", t, i, rsp_of(i)[34:33], csr_of(i)[46]);
        end
      end
      last_rr = win[1];
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    ena_cnt[0] = 0; ena_cnt[1] = 0; acc_cnt[0] = 0; acc_cnt[1] = 0;
    prev_ena[0] = 1'b0; prev_ena[1] = 1'b0;
    test_reset();
    test_write();
    test_hold();
    test_arb();
    test_ilgl();
    test_nop();
    test_rst_mid();
    test_random();
    step(); step();
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (ena_cnt[i] != acc_cnt[i] || acc_cnt[i] == 0) begin
        n_fail++; $display("FAIL ena_per_accept inst%0d got %0d strobes exp %0d (nonzero)", i, ena_cnt[i], acc_cnt[i]);
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
